// File: rtl/fade_seq_pkg.sv
// ----------------------------------------------------------------------------
// fade_seq_pkg
// Shared types and helpers for the fade_sequencer block.
//   fsm_state_e : sequencer FSM states (IDLE / FIRE / WAIT / FINISH)
//   LOOP_W      : width of the sweep (loop) counter
//   clog2_min1  : ceil(log2(value)) clamped to at least 1, for vector widths
// ----------------------------------------------------------------------------
package fade_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } fsm_state_e;

    localparam int LOOP_W = 16;

    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/step_timer.sv
// ----------------------------------------------------------------------------
// step_timer
// Up-counter that measures the WAIT interval between trigger pulses.
// While clear is high the count is held at zero; once clear drops it counts
// up every cycle and raises expire for exactly one cycle when the count
// equals TERM_COUNT.
// Ports:
//   CLK    in  system clock
//   RST    in  asynchronous active-high reset
//   clear  in  hold the count at zero
//   expire out single-cycle pulse at the terminal count
// ----------------------------------------------------------------------------
module step_timer
    import fade_seq_pkg::*;
#(
    parameter int TERM_COUNT = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic expire
);

    // Width sized for TERM_COUNT+1, so the "spent" value below always fits.
    localparam int CNT_W = clog2_min1(TERM_COUNT + 2);
    localparam logic [CNT_W-1:0] TERM_V  = CNT_W'(TERM_COUNT);
    localparam logic [CNT_W-1:0] SPENT_V = CNT_W'(TERM_COUNT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // The count parks one past the terminal value, so expire can never
    // repeat before the next clear.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != SPENT_V) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = !clear && (count_q == TERM_V);

endmodule

// File: rtl/fade_sequencer.sv
// ----------------------------------------------------------------------------
// fade_sequencer
// Trigger scheduler for a bank of N_CH LED faders. After START it fires a
// one-cycle one-hot pulse on SIG for one channel every STEP_CYCLES cycles,
// sweeping the channels LOOPS times (LOOPS=0 runs until STOP), then strobes
// DONE. STOP aborts from any active state without a DONE strobe.
// Optional build macro FADE_SEQ_BOUNCE_EN selects ping-pong channel order
// (0..N-1, N-2..0, 1..N-1, ...) instead of wrap order (0..N-1, 0..N-1, ...).
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   START  in   begin a sequence (honoured in IDLE only)
//   STOP   in   abort (honoured in every state)
//   SIG    out  one-hot trigger pulse, one cycle per fire
//   CH     out  current channel index
//   BUSY   out  high from accepted START until DONE or abort
//   DONE   out  single-cycle completion strobe
// All outputs are registered.
// ----------------------------------------------------------------------------
module fade_sequencer
    import fade_seq_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int STEP_CYCLES = 1000,
    parameter int LOOPS       = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic                        STOP,
    output logic [N_CH-1:0]             SIG,
    output logic [clog2_min1(N_CH)-1:0] CH,
    output logic                        BUSY,
    output logic                        DONE
);

    localparam int CH_W = clog2_min1(N_CH);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = (LOOPS == 0) ? '0 : LOOP_W'(LOOPS - 1);
    localparam bit                FINITE    = (LOOPS != 0);

    fsm_state_e        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic [N_CH-1:0]   sig_q, sig_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              timer_clear;
    logic              step_expire;

    // Channel that follows ch_q, and whether leaving ch_q ends a sweep.
    logic [CH_W-1:0]   next_ch;
    logic              sweep_end;

`ifdef FADE_SEQ_BOUNCE_EN
    logic dir_down_q, dir_down_d;
    logic next_dir_down;
`endif

    // The timer only runs in WAIT; every other state holds it at zero, so
    // the first WAIT cycle sees count 0 and expire lands at STEP_CYCLES-2.
    assign timer_clear = (state_q != ST_WAIT);

    step_timer #(
        .TERM_COUNT (STEP_CYCLES - 2)
    ) u_step_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (timer_clear),
        .expire (step_expire)
    );

    // ------------------------------------------------------------------
    // Channel order
    // ------------------------------------------------------------------
    always_comb begin
        next_ch   = '0;
        sweep_end = 1'b0;
`ifdef FADE_SEQ_BOUNCE_EN
        next_dir_down = dir_down_q;
        if (N_CH == 1) begin
            sweep_end = 1'b1;
        end else if (!dir_down_q) begin
            if (ch_q == CH_LAST) begin
                // Turn around without re-firing the end channel.
                next_ch       = ch_q - CH_W'(1);
                sweep_end     = 1'b1;
                next_dir_down = 1'b1;
            end else begin
                next_ch = ch_q + CH_W'(1);
            end
        end else begin
            if (ch_q == '0) begin
                next_ch       = CH_W'(1);
                sweep_end     = 1'b1;
                next_dir_down = 1'b0;
            end else begin
                next_ch = ch_q - CH_W'(1);
            end
        end
`else
        if (ch_q == CH_LAST) begin
            sweep_end = 1'b1;
        end else begin
            next_ch = ch_q + CH_W'(1);
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM next-state and registered-output values
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        loop_d  = loop_q;
        sig_d   = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FADE_SEQ_BOUNCE_EN
        dir_down_d = dir_down_q;
`endif
        if ((state_q != ST_IDLE) && STOP) begin
            // Abort: CH keeps its last value, no DONE strobe.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
`ifdef FADE_SEQ_BOUNCE_EN
            dir_down_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_d = 1'b0;
                    if (START && !STOP) begin
                        state_d = ST_FIRE;
                        ch_d    = '0;
                        loop_d  = '0;
                        busy_d  = 1'b1;
                        sig_d   = N_CH'(1);
`ifdef FADE_SEQ_BOUNCE_EN
                        dir_down_d = 1'b0;
`endif
                    end
                end
                ST_FIRE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (step_expire) begin
                        if (sweep_end && FINITE && (loop_q == LOOP_LAST)) begin
                            state_d = ST_FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_FIRE;
                            ch_d    = next_ch;
                            sig_d   = N_CH'(1) << next_ch;
                            // Saturate rather than wrap when LOOPS=0 runs long.
                            if (sweep_end && (loop_q != '1)) begin
                                loop_d = loop_q + LOOP_W'(1);
                            end
`ifdef FADE_SEQ_BOUNCE_EN
                            dir_down_d = next_dir_down;
`endif
                        end
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            loop_q  <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            loop_q  <= loop_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef FADE_SEQ_BOUNCE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dir_down_q <= 1'b0;
        end else begin
            dir_down_q <= dir_down_d;
        end
    end
`endif

    assign SIG  = sig_q;
    assign CH   = ch_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fade_sequencer
// Three sequencer instances share clock and reset:
//   dut0 : N_CH=4, STEP_CYCLES=5, LOOPS=2
//   dut1 : N_CH=4, STEP_CYCLES=5, LOOPS=0 (runs until STOP)
//   dut2 : N_CH=1, STEP_CYCLES=2, LOOPS=3
// A reference model predicts every output from "cycles since START":
// fire k happens at k*STEP_CYCLES on channel order(k), DONE follows the
// last fire by STEP_CYCLES cycles.
// ----------------------------------------------------------------------------
module tb_fade_sequencer;
    import fade_seq_pkg::*;

    localparam int NI = 3;

    int cfg_nch   [NI] = '{4, 4, 1};
    int cfg_step  [NI] = '{5, 5, 2};
    int cfg_loops [NI] = '{2, 0, 3};

    logic clk = 1'b0;
    logic rst;
    logic start [NI];
    logic stop  [NI];

    logic [3:0] sig0, sig1;
    logic [0:0] sig2;
    logic [1:0] ch0, ch1;
    logic [0:0] ch2;
    logic       busy [NI];
    logic       done [NI];

    logic [31:0] a_sig [NI];
    logic [31:0] a_ch  [NI];

    always #5 clk = ~clk;

    fade_sequencer #(.N_CH(4), .STEP_CYCLES(5), .LOOPS(2)) dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .STOP(stop[0]),
        .SIG(sig0), .CH(ch0), .BUSY(busy[0]), .DONE(done[0]));
    fade_sequencer #(.N_CH(4), .STEP_CYCLES(5), .LOOPS(0)) dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .STOP(stop[1]),
        .SIG(sig1), .CH(ch1), .BUSY(busy[1]), .DONE(done[1]));
    fade_sequencer #(.N_CH(1), .STEP_CYCLES(2), .LOOPS(3)) dut2 (
        .CLK(clk), .RST(rst), .START(start[2]), .STOP(stop[2]),
        .SIG(sig2), .CH(ch2), .BUSY(busy[2]), .DONE(done[2]));

    assign a_sig[0] = 32'(sig0);
    assign a_sig[1] = 32'(sig1);
    assign a_sig[2] = 32'(sig2);
    assign a_ch[0]  = 32'(ch0);
    assign a_ch[1]  = 32'(ch1);
    assign a_ch[2]  = 32'(ch2);

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_run  [NI];
    bit          m_fin  [NI];
    int          m_n    [NI];
    int          m_last [NI];
    logic [31:0] e_sig  [NI];
    logic [31:0] e_ch   [NI];
    bit          e_busy [NI];
    bit          e_done [NI];

    function automatic int ch_of(int i, int k);
        int nch;
        nch = cfg_nch[i];
`ifdef FADE_SEQ_BOUNCE_EN
        if (nch > 1) begin
            int per, p;
            per = 2 * (nch - 1);
            p   = k % per;
            return (p < nch) ? p : per - p;
        end
`endif
        return k % nch;
    endfunction

    function automatic int fires_total(int i);
        int nch;
        nch = cfg_nch[i];
`ifdef FADE_SEQ_BOUNCE_EN
        if (nch > 1) return nch + (cfg_loops[i] - 1) * (nch - 1);
`endif
        return cfg_loops[i] * nch;
    endfunction

    task automatic model_edge(input int i, input bit st, input bit sp, input bit rs);
        if (rs) begin
            m_run[i] = 0; m_fin[i] = 0; m_n[i] = 0; m_last[i] = 0;
        end else if (m_run[i]) begin
            if (sp) begin
                m_run[i] = 0;
            end else begin
                m_n[i]++;
                if (cfg_loops[i] != 0 && m_n[i] == fires_total(i) * cfg_step[i]) begin
                    m_run[i] = 0;
                    m_fin[i] = 1;
                end
            end
        end else if (m_fin[i]) begin
            m_fin[i] = 0;
        end else if (st && !sp) begin
            m_run[i] = 1;
            m_n[i]   = 0;
        end
        e_sig[i]  = '0;
        e_busy[i] = 0;
        e_done[i] = 0;
        if (m_run[i]) begin
            m_last[i] = ch_of(i, m_n[i] / cfg_step[i]);
            e_busy[i] = 1;
            if (m_n[i] % cfg_step[i] == 0) e_sig[i] = 32'd1 << m_last[i];
        end else if (m_fin[i]) begin
            e_done[i] = 1;
        end
        e_ch[i] = 32'(m_last[i]);
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_model(input int i);
        check("sig",  i, a_sig[i], e_sig[i]);
        check("ch",   i, a_ch[i],  e_ch[i]);
        check("busy", i, 32'(busy[i]), 32'(e_busy[i]));
        check("done", i, 32'(done[i]), 32'(e_done[i]));
    endtask

    // One clock: model advances on the same inputs the DUTs sample,
    // outputs are compared 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) model_edge(i, start[i], stop[i], rst);
        #1;
        for (int i = 0; i < NI; i++) check_model(i);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            stop[i]  = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table for dut0
    // ------------------------------------------------------------------
    typedef struct {
        int         gap;
        bit         st;
        bit         sp;
        logic [3:0] sig;
        logic [1:0] ch;
        bit         busy;
        bit         done;
    } vec_t;

    function automatic vec_t mk(int gap, bit st, bit sp, logic [3:0] sig, logic [1:0] ch, bit b, bit d);
        vec_t v;
        v.gap = gap; v.st = st; v.sp = sp; v.sig = sig; v.ch = ch; v.busy = b; v.done = d;
        return v;
    endfunction

    vec_t vecs [15];
    int   fires, dones;

    initial begin
        logic [1:0] last_ch;

        // Expected values are measured in cycles since the accepted START (n).
        vecs[0]  = mk(0,  1, 0, 4'b0001, 2'd0, 1, 0); // n=0 first fire
        vecs[1]  = mk(0,  0, 0, 4'b0000, 2'd0, 1, 0); // n=1 wait
        vecs[2]  = mk(3,  0, 0, 4'b0010, 2'd1, 1, 0); // n=5
        vecs[3]  = mk(0,  1, 0, 4'b0000, 2'd1, 1, 0); // n=6 START while busy
        vecs[4]  = mk(3,  0, 0, 4'b0100, 2'd2, 1, 0); // n=10 spacing kept
        vecs[5]  = mk(4,  0, 0, 4'b1000, 2'd3, 1, 0); // n=15
`ifdef FADE_SEQ_BOUNCE_EN
        last_ch  = 2'd0;
        vecs[6]  = mk(4,  0, 0, 4'b0100, 2'd2, 1, 0); // n=20 reversing
        vecs[7]  = mk(9,  0, 0, 4'b0001, 2'd0, 1, 0); // n=30 last fire
        vecs[8]  = mk(3,  0, 0, 4'b0000, 2'd0, 1, 0); // n=34
        vecs[9]  = mk(0,  1, 0, 4'b0000, 2'd0, 0, 1); // n=35 DONE, START ignored
`else
        last_ch  = 2'd3;
        vecs[6]  = mk(4,  0, 0, 4'b0001, 2'd0, 1, 0); // n=20 second sweep
        vecs[7]  = mk(14, 0, 0, 4'b1000, 2'd3, 1, 0); // n=35 last fire
        vecs[8]  = mk(3,  0, 0, 4'b0000, 2'd3, 1, 0); // n=39
        vecs[9]  = mk(0,  1, 0, 4'b0000, 2'd3, 0, 1); // n=40 DONE, START ignored
`endif
        vecs[10] = mk(0,  0, 0, 4'b0000, last_ch, 0, 0); // back in IDLE
        vecs[11] = mk(0,  1, 1, 4'b0000, last_ch, 0, 0); // START+STOP: stay IDLE
        vecs[12] = mk(0,  1, 0, 4'b0001, 2'd0, 1, 0);    // restart
        vecs[13] = mk(10, 0, 1, 4'b0000, 2'd2, 0, 0);    // STOP at n=11
        vecs[14] = mk(0,  0, 0, 4'b0000, 2'd2, 0, 0);    // no DONE after abort

        // Reset state
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < NI; i++) model_edge(i, 1'b0, 1'b0, 1'b1);
        #2;
        for (int i = 0; i < NI; i++) check_model(i);
        cycle();
        cycle();
        rst = 1'b0;

        // Table
        for (int e = 0; e < 15; e++) begin
            for (int g = 0; g < vecs[e].gap; g++) cycle();
            start[0] = vecs[e].st;
            stop[0]  = vecs[e].sp;
            cycle();
            start[0] = 1'b0;
            stop[0]  = 1'b0;
            check("tbl_sig",  0, a_sig[0], 32'(vecs[e].sig));
            check("tbl_ch",   0, a_ch[0],  32'(vecs[e].ch));
            check("tbl_busy", 0, 32'(busy[0]), 32'(vecs[e].busy));
            check("tbl_done", 0, 32'(done[0]), 32'(vecs[e].done));
        end
        repeat (3) cycle();

        // Asynchronous reset in the middle of WAIT
        start[0] = 1'b1;
        cycle();
        start[0] = 1'b0;
        repeat (6) cycle();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) model_edge(i, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) check_model(i);
        cycle();
        rst = 1'b0;
        start[0] = 1'b1;
        cycle();
        start[0] = 1'b0;
        check("rst_restart_sig", 0, a_sig[0], 32'd1);
        stop[0] = 1'b1;
        cycle();
        stop[0] = 1'b0;

        // LOOPS=0 instance: six sweeps with no DONE, then STOP
        fires = 0;
        dones = 0;
        start[1] = 1'b1;
        cycle();
        start[1] = 1'b0;
        if (sig1 != 4'b0) fires++;
        repeat (120) begin
            cycle();
            if (sig1 != 4'b0) fires++;
            if (done[1]) dones++;
        end
        check("inf_fires", 1, 32'(fires), 32'd25);
        check("inf_dones", 1, 32'(dones), 32'd0);
        stop[1] = 1'b1;
        cycle();
        stop[1] = 1'b0;
        check("inf_stop_busy", 1, 32'(busy[1]), 32'd0);

        // N_CH=1 instance: every WAIT exit completes a sweep, 3 sweeps
        fires = 0;
        dones = 0;
        start[2] = 1'b1;
        cycle();
        start[2] = 1'b0;
        if (sig2 != 1'b0) fires++;
        repeat (8) begin
            cycle();
            if (sig2 != 1'b0) fires++;
            if (done[2]) dones++;
        end
        check("one_ch_fires", 2, 32'(fires), 32'd3);
        check("one_ch_dones", 2, 32'(dones), 32'd1);

        // Random START/STOP traffic on all instances
        repeat (3000) begin
            for (int i = 0; i < NI; i++) begin
                start[i] = ($urandom_range(0, 15) == 0);
                stop[i]  = ($urandom_range(0, 63) == 0);
            end
            cycle();
        end
        idle_inputs();
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
